multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter USE_MEM_READY, default 1: when 1, memory states wait for mem_ready; when 0, mem_ready is ignored and treated as 1.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Op  input  11  opcode field Instr[31:21] from the instruction register; stable from DECODE until the next FETCH.
REQ-005 Zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  data/instruction memory completion strobe for the current access.
REQ-007 PCWrite, IRWrite, RegWrite, MemRead, MemWrite  output  1 each  write/access strobes.
REQ-008 IorD (0=PC, 1=ALUOut), MemtoReg (0=ALUOut, 1=MDR), Reg2Loc (1=Rt as read reg 2), PCSrc (0=ALU result, 1=ALUOut), ALUSrcA (0=PC, 1=reg A)  output  1 each  mux selects.
REQ-009 ALUSrcB  output  2  00=reg B, 01=constant 4, 10=sign-extended D-immediate, 11=branch offset shifted left 2.
REQ-010 ALUOp  output  2  00=add, 01=pass-B/compare, 10=decode funct.
REQ-011 state  output  4  current state encoding, for debug.
REQ-012 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-013 instr_count  output  32  retired-instruction counter.

Function
REQ-014 State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, ALUWB=7, BRANCH=8; codes 9-15 are unreachable and transition to FETCH.
REQ-015 Opcode classes: LDUR=11'b11111000010; STUR=11'b11111000000; CBZ=11'b10110100xxx; R-type = ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000; every other value is illegal.
REQ-016 Outputs not listed for a state are 0.
REQ-017 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=0; IRWrite=PCWrite=mem_ready; FETCH holds until mem_ready=1, then goes to DECODE.
REQ-018 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; Reg2Loc=1 for STUR/CBZ; next state MEMADR (LDUR/STUR), EXEC_R (R-type), BRANCH (CBZ); on an illegal opcode, illegal_op=1 and the next state is FETCH.
REQ-019 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, Reg2Loc=1 for STUR; next state MEMRD (LDUR) or MEMWR (STUR).
REQ-020 MEMRD: IorD=1, MemRead=1; holds until mem_ready, then goes to MEMWB.
REQ-021 MEMWB: RegWrite=1, MemtoReg=1; next state FETCH.
REQ-022 MEMWR: IorD=1, MemWrite=1, Reg2Loc=1; holds until mem_ready, then goes to FETCH.
REQ-023 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state ALUWB.
REQ-024 ALUWB: RegWrite=1, MemtoReg=0; next state FETCH.
REQ-025 BRANCH: Reg2Loc=1, ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=1, PCWrite=Zero; next state FETCH.
REQ-026 Cycles per instruction with mem_ready always 1: LDUR 5, STUR 4, R-type 4, CBZ 3, illegal 2.
REQ-027 instr_count increments by 1 on each edge leaving MEMWB, leaving MEMWR with mem_ready=1, leaving ALUWB, or leaving BRANCH; it wraps from 0xFFFFFFFF to 0; illegal opcodes are not counted.
REQ-028 A mem_ready pulse outside FETCH, MEMRD or MEMWR has no effect.

Reset
REQ-029 While reset=1: state=FETCH, instr_count=0, illegal_op=0, and all outputs of REQ-007..REQ-010 are forced to 0, even though FETCH would otherwise drive MemRead=1.
REQ-030 Reset asserted mid-instruction aborts that instruction immediately, asynchronously; the aborted instruction is not counted and no strobe remains asserted.
REQ-031 After reset deasserts, the first rising edge evaluates FETCH normally.

Verification
REQ-032 Reset; mem_ready=1; Op=LDUR -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; instr_count=1.
REQ-033 Op=STUR, mem_ready held 0 for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, IorD=1; no RegWrite; then FETCH with instr_count incremented.
REQ-034 Op=CBZ (11'b10110100101), Zero=1 -> PCWrite=1 and PCSrc=1 in BRANCH; repeat with Zero=0 -> PCWrite=0; both take 3 cycles.
REQ-035 Op=ADD, then SUB, AND, ORR -> each takes 4 cycles, ALUOp=10 in EXEC_R; Op=11'h000 -> illegal_op pulses for 1 cycle, back to FETCH, count unchanged.
REQ-036 Reset asserted asynchronously in MEMRD -> state=0 and MemRead=0 before the next edge, instr_count=0; USE_MEM_READY=0 with mem_ready=0 -> LDUR still completes in 5 cycles.
REQ-037 Preload instr_count to 0xFFFFFFFF via force, run one R-type -> instr_count=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control unit: FSM driving datapath strobes and mux selects for LDUR/STUR/CBZ/R-type.
// Outputs are decoded combinationally from state; memory states stall on mem_ready when USE_MEM_READY=1.
module multicycle_ctrl #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] Op,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        MemtoReg,
  output logic        Reg2Loc,
  output logic        PCSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [3:0]  state,
  output logic        illegal_op,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC_R = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8
  } state_t;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;

  state_t      state_q, state_d;
  logic [31:0] count_q;
  logic        mr;
  logic        is_ldur, is_stur, is_cbz, is_rtype;
  logic        retire;

  logic        pcwrite_c, irwrite_c, regwrite_c, memread_c, memwrite_c;
  logic        iord_c, memtoreg_c, reg2loc_c, pcsrc_c, alusrca_c, illegal_c;
  logic [1:0]  alusrcb_c, aluop_c;

  assign mr       = USE_MEM_READY ? mem_ready : 1'b1;
  assign is_ldur  = (Op == OP_LDUR);
  assign is_stur  = (Op == OP_STUR);
  assign is_cbz   = (Op[10:3] == OP_CBZ);
  assign is_rtype = (Op == OP_ADD) || (Op == OP_SUB) || (Op == OP_AND) || (Op == OP_ORR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (retire) count_q <= count_q + 32'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    pcwrite_c  = 1'b0;
    irwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    iord_c     = 1'b0;
    memtoreg_c = 1'b0;
    reg2loc_c  = 1'b0;
    pcsrc_c    = 1'b0;
    alusrca_c  = 1'b0;
    alusrcb_c  = 2'b00;
    aluop_c    = 2'b00;
    illegal_c  = 1'b0;

    case (state_q)
      FETCH: begin
        memread_c = 1'b1;
        alusrcb_c = 2'b01;
        irwrite_c = mr;
        pcwrite_c = mr;
        if (mr) state_d = DECODE;
      end
      DECODE: begin
        alusrcb_c = 2'b11;
        reg2loc_c = is_stur || is_cbz;
        if (is_ldur || is_stur) state_d = MEMADR;
        else if (is_rtype)      state_d = EXEC_R;
        else if (is_cbz)        state_d = BRANCH;
        else begin
          illegal_c = 1'b1;
          state_d   = FETCH;
        end
      end
      MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        reg2loc_c = is_stur;
        state_d   = is_stur ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord_c    = 1'b1;
        memread_c = 1'b1;
        if (mr) state_d = MEMWB;
      end
      MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg_c = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        iord_c     = 1'b1;
        memwrite_c = 1'b1;
        reg2loc_c  = 1'b1;
        if (mr) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      EXEC_R: begin
        alusrca_c = 1'b1;
        aluop_c   = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        regwrite_c = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        reg2loc_c = 1'b1;
        alusrca_c = 1'b1;
        aluop_c   = 2'b01;
        pcsrc_c   = 1'b1;
        pcwrite_c = Zero;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset masks every strobe so FETCH's MemRead is not visible while held in reset.
  always_comb begin
    PCWrite    = pcwrite_c  & ~reset;
    IRWrite    = irwrite_c  & ~reset;
    RegWrite   = regwrite_c & ~reset;
    MemRead    = memread_c  & ~reset;
    MemWrite   = memwrite_c & ~reset;
    IorD       = iord_c     & ~reset;
    MemtoReg   = memtoreg_c & ~reset;
    Reg2Loc    = reg2loc_c  & ~reset;
    PCSrc      = pcsrc_c    & ~reset;
    ALUSrcA    = alusrca_c  & ~reset;
    ALUSrcB    = alusrcb_c  & {2{~reset}};
    ALUOp      = aluop_c    & {2{~reset}};
    illegal_op = illegal_c  & ~reset;
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule
